// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit add/subtract computed CHUNK bits per clock, LSB chunk first.
// OUT, CARRY and OVERFLOW are registered and change only when an operation completes.
module multicycle_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  output logic [WIDTH-1:0] OUT,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             BUSY,
  output logic             DONE
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             capture_s, last_s;
  logic [WIDTH-1:0] a_r, b_r, res_r, res_s;
  logic [KW-1:0]    k_r;
  logic             c_r;
  logic [CHUNK-1:0] a_chunk_s, b_chunk_s;
  logic [CHUNK:0]   sum_s;
  logic             ovf_s;
  logic [WIDTH-1:0] out_r;
  logic             carry_r, ovf_r, busy_r, done_r;

  // Next-state decode; START is only honoured outside RUN, so nothing is queued while busy.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    last_s    = 1'b0;
    case (state_r)
      IDLE, FIN: begin
        if (START) begin
          capture_s = 1'b1;
          state_s   = RUN;
        end else begin
          state_s   = IDLE;
        end
      end
      RUN: begin
        if (k_r == K_LAST) begin
          last_s  = 1'b1;
          state_s = FIN;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // One ripple step: slice k of both operands plus the running carry.
  always_comb begin
    a_chunk_s = a_r[k_r*CHUNK +: CHUNK];
    b_chunk_s = b_r[k_r*CHUNK +: CHUNK];
    sum_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, c_r};
    // Equal operand signs with a differing result sign is carry-in XOR carry-out at the MSB.
    ovf_s     = (a_chunk_s[CHUNK-1] == b_chunk_s[CHUNK-1]) &&
                (sum_s[CHUNK-1] != a_chunk_s[CHUNK-1]);
    res_s     = res_r;
    res_s[k_r*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
  end

  // State register and the BUSY/DONE flags derived from the next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == FIN);
    end
  end

  // Operand capture, chunk accumulation and the held result registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      k_r     <= {KW{1'b0}};
      out_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (capture_s) begin
      a_r <= IN1;
      b_r <= SUB ? ~IN2 : IN2;
      c_r <= SUB;
      k_r <= {KW{1'b0}};
    end else if (state_r == RUN) begin
      res_r <= res_s;
      c_r   <= sum_s[CHUNK];
      k_r   <= k_r + KW'(1);
      if (last_s) begin
        out_r   <= res_s;
        carry_r <= sum_s[CHUNK];
        ovf_r   <= ovf_s;
      end else begin
        out_r   <= out_r;
      end
    end else begin
      c_r <= c_r;
    end
  end

  assign OUT      = out_r;
  assign CARRY    = carry_r;
  assign OVERFLOW = ovf_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three configurations (8/4, 4/1, 8/8) checked every cycle
// against an arithmetic reference model, plus directed vectors with literal expectations.
module tb_multicycle_adder;
  logic clk = 1'b0;
  logic rst;
  logic start_a [3];
  logic sub_a   [3];
  logic [7:0] in1_a [3];
  logic [7:0] in2_a [3];
  wire  [7:0] out0, out2;
  wire  [3:0] out1;
  wire  [2:0] carry_v, ovf_v, busy_v, done_v;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  localparam int MW [3] = '{8, 4, 8};
  localparam int MN [3] = '{2, 4, 1};

  int         m_cnt [3] = '{0, 0, 0};
  logic       m_fin [3];
  logic [9:0] m_res [3];
  logic [9:0] m_pend[3];

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(8), .CHUNK(4)) dut0 (
    .CLK(clk), .RESET(rst), .START(start_a[0]), .SUB(sub_a[0]), .IN1(in1_a[0]), .IN2(in2_a[0]),
    .OUT(out0), .CARRY(carry_v[0]), .OVERFLOW(ovf_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]));
  multicycle_adder #(.WIDTH(4), .CHUNK(1)) dut1 (
    .CLK(clk), .RESET(rst), .START(start_a[1]), .SUB(sub_a[1]), .IN1(in1_a[1][3:0]), .IN2(in2_a[1][3:0]),
    .OUT(out1), .CARRY(carry_v[1]), .OVERFLOW(ovf_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]));
  multicycle_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
    .CLK(clk), .RESET(rst), .START(start_a[2]), .SUB(sub_a[2]), .IN1(in1_a[2]), .IN2(in2_a[2]),
    .OUT(out2), .CARRY(carry_v[2]), .OVERFLOW(ovf_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2]));

  // Reference result {overflow, carry, out} from signed/unsigned arithmetic.
  function automatic logic [9:0] calc(input int w, input logic sub, input logic [7:0] x, input logic [7:0] y);
    int mask, half, a, b, sa, sb, ur, r;
    logic c, v;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    a  = int'(x) & mask;
    b  = int'(y) & mask;
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    if (sub) begin
      ur = a - b;  c = (a >= b);         r = sa - sb;
    end else begin
      ur = a + b;  c = (ur >= (1 << w)); r = sa + sb;
    end
    v = (r < -half) || (r > half - 1);
    return {v, c, 8'(ur & mask)};
  endfunction

  function automatic int act_out(input int i);
    case (i)
      0:       return int'(out0);
      1:       return int'(out1);
      default: return int'(out2);
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int i, input logic sub, input logic [7:0] a, input logic [7:0] b);
    start_a[i] = 1'b1; sub_a[i] = sub; in1_a[i] = a; in2_a[i] = b;
    tick();
    start_a[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int exp_lat, input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done_v[i] && n < 20);
    check({nm, "_latency"}, n, exp_lat);
  endtask

  // Reference model: an op runs for N edges after capture, then one FIN cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_cnt[i] <= 0;
        m_fin[i] <= 1'b0;
        m_res[i] <= 10'd0;
      end else if (m_cnt[i] > 0) begin
        m_cnt[i] <= m_cnt[i] - 1;
        m_fin[i] <= (m_cnt[i] == 1);
        if (m_cnt[i] == 1) m_res[i] <= m_pend[i];
      end else begin
        m_fin[i] <= 1'b0;
        if (start_a[i]) begin
          m_cnt[i]  <= MN[i];
          m_pend[i] <= calc(MW[i], sub_a[i], in1_a[i], in2_a[i]);
        end
      end
    end
  end

  // Every-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("m%0d_busy", i), int'(busy_v[i]), int'(m_cnt[i] > 0));
        check($sformatf("m%0d_done", i), int'(done_v[i]), int'(m_fin[i]));
        check($sformatf("m%0d_out", i), act_out(i), int'(m_res[i][7:0]));
        check($sformatf("m%0d_carry", i), int'(carry_v[i]), int'(m_res[i][8]));
        check($sformatf("m%0d_ovf", i), int'(ovf_v[i]), int'(m_res[i][9]));
      end
    end
  end

  initial begin
    int e;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0; sub_a[i] = 1'b0; in1_a[i] = 8'h00; in2_a[i] = 8'h00;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    check("rst_out", act_out(0), 0);
    check("rst_busy", int'(busy_v), 0);
    check("rst_done", int'(done_v), 0);
    check("rst_flags", int'({carry_v, ovf_v}), 0);
    check("model_pin_add", int'(calc(8, 1'b0, 8'h7F, 8'h01)), int'(10'h280));
    check("model_pin_sub", int'(calc(8, 1'b1, 8'h80, 8'h01)), int'(10'h37F));

    // 0x7F + 0x01: signed overflow, two-cycle latency
    launch(0, 1'b0, 8'h7F, 8'h01);
    check("t1_busy_t", int'(busy_v[0]), 1);
    check("t1_done_t", int'(done_v[0]), 0);
    tick();
    check("t1_busy_t1", int'(busy_v[0]), 1);
    tick();
    check("t1_done", int'(done_v[0]), 1);
    check("t1_busy_end", int'(busy_v[0]), 0);
    check("t1_out", act_out(0), 8'h80);
    check("t1_carry", int'(carry_v[0]), 0);
    check("t1_ovf", int'(ovf_v[0]), 1);
    tick();
    check("t1_done_drop", int'(done_v[0]), 0);
    check("t1_hold", act_out(0), 8'h80);

    launch(0, 1'b0, 8'hFF, 8'h01);
    wait_done(0, 2, "add_ff");
    check("add_ff_res", int'({ovf_v[0], carry_v[0], out0}), int'({1'b0, 1'b1, 8'h00}));
    launch(0, 1'b1, 8'h00, 8'h01);
    wait_done(0, 2, "sub_00");
    check("sub_00_res", int'({ovf_v[0], carry_v[0], out0}), int'({1'b0, 1'b0, 8'hFF}));
    launch(0, 1'b1, 8'h80, 8'h01);
    wait_done(0, 2, "sub_80");
    check("sub_80_res", int'({ovf_v[0], carry_v[0], out0}), int'({1'b1, 1'b1, 8'h7F}));

    // START and new operands while busy are ignored; START held in FIN chains with no bubble
    launch(0, 1'b0, 8'h11, 8'h22);
    start_a[0] = 1'b1; sub_a[0] = 1'b1; in1_a[0] = 8'hAA; in2_a[0] = 8'h55;
    tick();
    start_a[0] = 1'b0;
    tick();
    check("ign_done", int'(done_v[0]), 1);
    check("ign_out", act_out(0), 8'h33);
    start_a[0] = 1'b1; sub_a[0] = 1'b0; in1_a[0] = 8'h10; in2_a[0] = 8'h20;
    tick();
    start_a[0] = 1'b0;
    check("b2b_busy", int'(busy_v[0]), 1);
    tick();
    check("b2b_done_early", int'(done_v[0]), 0);
    tick();
    check("b2b_done", int'(done_v[0]), 1);
    check("b2b_out", act_out(0), 8'h30);
    tick();
    check("no_queue", int'(done_v[0]), 0);

    // Reset mid-run aborts with no DONE and clears the result
    launch(0, 1'b0, 8'h12, 8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("abort_busy", int'(busy_v[0]), 0);
    check("abort_done", int'(done_v[0]), 0);
    check("abort_out", act_out(0), 8'h00);
    for (int j = 0; j < 5; j++) begin
      tick();
      check("abort_no_done", int'(done_v[0]), 0);
    end

    // Reset wins over START in the same cycle; the next START works normally
    rst = 1'b1;
    start_a[0] = 1'b1; in1_a[0] = 8'h05; in2_a[0] = 8'h03;
    tick();
    rst = 1'b0;
    start_a[0] = 1'b0;
    check("prio_busy", int'(busy_v[0]), 0);
    tick();
    check("prio_idle", int'({busy_v[0], done_v[0]}), 0);
    launch(0, 1'b0, 8'h05, 8'h03);
    wait_done(0, 2, "post_rst");
    check("post_rst_out", act_out(0), 8'h08);

    // Single-chunk configuration: one-cycle latency
    launch(2, 1'b0, 8'h01, 8'h02);
    check("c8_busy", int'(busy_v[2]), 1);
    tick();
    check("c8_done", int'(done_v[2]), 1);
    check("c8_out", act_out(2), 8'h03);
    launch(2, 1'b1, 8'h00, 8'h01);
    wait_done(2, 1, "c8_sub");
    check("c8_sub_res", int'({ovf_v[2], carry_v[2], out2}), int'({1'b0, 1'b0, 8'hFF}));

    // Exhaustive 4-bit sweep, one bit per cycle
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          launch(1, s[0], 8'(a), 8'(b));
          wait_done(1, 4, "sweep");
          e = (s == 0) ? (a + b) : (a + ((~b) & 15) + 1);
          check($sformatf("sweep_%0d_%0h_%0h", s, a, b), int'({carry_v[1], out1}), e & 31);
        end
      end
    end

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
